// File: rtl/pa_protect_pkg.sv
// ---------------------------------------------------------------------------
// pa_protect_pkg
// Shared definitions for the PA protection block:
//   - state_t        : protection FSM states
//   - CAUSE_*        : trip_cause encoding
//   - DEF_*          : default trip thresholds
//   - select_cause() : fixed-priority cause encoder (fwd > ref > swr)
// ---------------------------------------------------------------------------
package pa_protect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIP  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_FWD  = 2'd1;
  localparam logic [1:0] CAUSE_REF  = 2'd2;
  localparam logic [1:0] CAUSE_SWR  = 2'd3;

  localparam logic [11:0] DEF_FWD_LIMIT = 12'd3500;
  localparam logic [11:0] DEF_REF_LIMIT = 12'd1200;
  localparam logic [11:0] DEF_FWD_MIN   = 12'd400;

  // Highest-priority active condition wins; CAUSE_NONE when nothing applies.
  function automatic logic [1:0] select_cause(input logic fwd_hi,
                                              input logic ref_hi,
                                              input logic swr_hi);
    logic [1:0] cause;
    if (fwd_hi) begin
      cause = CAUSE_FWD;
    end else if (ref_hi) begin
      cause = CAUSE_REF;
    end else if (swr_hi) begin
      cause = CAUSE_SWR;
    end else begin
      cause = CAUSE_NONE;
    end
    return cause;
  endfunction

endpackage

// File: rtl/pa_ema.sv
// ---------------------------------------------------------------------------
// pa_ema
// Single-channel exponential moving average.
//   acc <= acc - (acc >> AVG_SHIFT) + sample   on every tick
//   avg  = acc >> AVG_SHIFT                     registered with the same tick
// The accumulator is 12+AVG_SHIFT bits wide; its steady state is bounded by
// 4095 << AVG_SHIFT, so it cannot overflow and needs no saturation.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   tick         : one-cycle sample strobe
//   sample       : 12-bit telemetry sample
//   avg          : 12-bit averaged value (valid the cycle after tick)
// ---------------------------------------------------------------------------
module pa_ema #(
  parameter int AVG_SHIFT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic [11:0] sample,
  output logic [11:0] avg
);

  localparam int AW = 12 + AVG_SHIFT;

  logic [AW-1:0] acc_r;
  logic [AW-1:0] acc_next_s;
  logic [11:0]   avg_r;

  // Next accumulator value: leak one 2^-AVG_SHIFT fraction, add the new sample.
  always_comb begin
    acc_next_s = acc_r - (acc_r >> AVG_SHIFT) + AW'(sample);
  end

  // Accumulator and output average; the average is taken from the new
  // accumulator so both move on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_r <= {AW{1'b0}};
      avg_r <= 12'd0;
    end else if (tick) begin
      acc_r <= acc_next_s;
      avg_r <= 12'(acc_next_s >> AVG_SHIFT);
    end else begin
      acc_r <= acc_r;
      avg_r <= avg_r;
    end
  end

  assign avg = avg_r;

endmodule

// File: rtl/pa_protect.sv
// ---------------------------------------------------------------------------
// pa_protect
// Power-amplifier protection: averages forward/reflected power telemetry on
// a slow sample tick, trips on over-forward, over-reflected or (optionally)
// high-SWR conditions while transmitting, and inhibits transmit for a hold
// period afterwards.
//
// Build option: define PA_PROTECT_SWR_EN to include the SWR check
// (fwd_avg >= FWD_MIN and 4*ref_avg > fwd_avg). Without it no SWR logic is
// built and trip_cause never reports SWR.
//
// Ports:
//   clock      : system clock (80 kHz)
//   reset      : asynchronous active-high reset
//   init_done  : telemetry link configured (level)
//   ain1/ain2  : forward / reflected power telemetry, 12 bit
//   ptt        : transmit request from host
//   ptt_out    : gated transmit enable = ptt & ~inhibit
//   fwd_avg    : averaged ain1
//   ref_avg    : averaged ain2
//   trip       : one-cycle pulse on entry to TRIP
//   trip_cause : latched cause (0 none, 1 fwd, 2 ref, 3 swr)
// ---------------------------------------------------------------------------
module pa_protect
  import pa_protect_pkg::*;
#(
  parameter int          SAMPLE_DIV = 800,
  parameter int          AVG_SHIFT  = 3,
  parameter logic [11:0] FWD_LIMIT  = DEF_FWD_LIMIT,
  parameter logic [11:0] REF_LIMIT  = DEF_REF_LIMIT,
  parameter int          HOLD_TICKS = 100,
  parameter logic [11:0] FWD_MIN    = DEF_FWD_MIN
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        init_done,
  input  logic [11:0] ain1,
  input  logic [11:0] ain2,
  input  logic        ptt,
  output logic        ptt_out,
  output logic [11:0] fwd_avg,
  output logic [11:0] ref_avg,
  output logic        trip,
  output logic [1:0]  trip_cause
);

  // Elaboration-time parameter range checks.
  generate
    if (SAMPLE_DIV < 2 || SAMPLE_DIV > 65535) begin : g_bad_div
      $error("pa_protect: SAMPLE_DIV out of range 2..65535");
    end
    if (AVG_SHIFT < 0 || AVG_SHIFT > 4) begin : g_bad_shift
      $error("pa_protect: AVG_SHIFT out of range 0..4");
    end
    if (HOLD_TICKS < 1 || HOLD_TICKS > 255) begin : g_bad_hold
      $error("pa_protect: HOLD_TICKS out of range 1..255");
    end
  endgenerate

  localparam logic [15:0] DIV_LAST  = 16'(SAMPLE_DIV - 1);
  localparam logic [7:0]  HOLD_LOAD = 8'(HOLD_TICKS);

  logic [15:0] cnt_r;
  logic        tick_s;
  logic [11:0] fwd_avg_s;
  logic [11:0] ref_avg_s;
  logic        fwd_hi_s;
  logic        ref_hi_s;
  logic        swr_hi_s;
  logic        any_hi_s;
  logic [1:0]  cause_s;

  state_t      state_r;
  logic        inhibit_r;
  logic        trip_r;
  logic [1:0]  cause_r;
  logic [7:0]  hold_r;

  // ---------------------------------------------------------------------
  // Sample tick generation
  // ---------------------------------------------------------------------
  assign tick_s = init_done && (cnt_r == DIV_LAST);

  // Tick divider: free-runs 0..SAMPLE_DIV-1 while the link is up, parked at 0 otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= 16'd0;
    end else if (!init_done) begin
      cnt_r <= 16'd0;
    end else if (tick_s) begin
      cnt_r <= 16'd0;
    end else begin
      cnt_r <= cnt_r + 16'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Averaging channels
  // ---------------------------------------------------------------------
  pa_ema #(.AVG_SHIFT(AVG_SHIFT)) u_ema_fwd (
    .clock  (clock),
    .reset  (reset),
    .tick   (tick_s),
    .sample (ain1),
    .avg    (fwd_avg_s)
  );

  pa_ema #(.AVG_SHIFT(AVG_SHIFT)) u_ema_ref (
    .clock  (clock),
    .reset  (reset),
    .tick   (tick_s),
    .sample (ain2),
    .avg    (ref_avg_s)
  );

  // ---------------------------------------------------------------------
  // Limit conditions (on the registered averages)
  // ---------------------------------------------------------------------
  assign fwd_hi_s = (fwd_avg_s > FWD_LIMIT);
  assign ref_hi_s = (ref_avg_s > REF_LIMIT);

`ifdef PA_PROTECT_SWR_EN
  // 4*ref > fwd is reflection coefficient above 1/2 in amplitude terms;
  // both sides are widened to 14 bits so the shift cannot drop bits.
  assign swr_hi_s = (fwd_avg_s >= FWD_MIN) &&
                    ({ref_avg_s, 2'b00} > {2'b00, fwd_avg_s});
`else
  logic unused_fwd_min_s;
  assign unused_fwd_min_s = ^FWD_MIN;
  assign swr_hi_s = 1'b0;
`endif

  assign any_hi_s = fwd_hi_s | ref_hi_s | swr_hi_s;
  assign cause_s  = select_cause(fwd_hi_s, ref_hi_s, swr_hi_s);

  // ---------------------------------------------------------------------
  // Protection FSM. inhibit is registered together with the state so it is
  // already high in the first TRIP cycle and low in the first ARMED cycle.
  // ---------------------------------------------------------------------
  // Protection state machine with registered inhibit, trip pulse, cause and hold counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      inhibit_r <= 1'b1;
      trip_r    <= 1'b0;
      cause_r   <= CAUSE_NONE;
      hold_r    <= 8'd0;
    end else begin
      trip_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (init_done) begin
            state_r   <= ST_ARMED;
            inhibit_r <= 1'b0;
          end else begin
            inhibit_r <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (!init_done) begin
            state_r   <= ST_IDLE;
            inhibit_r <= 1'b1;
          end else if (ptt && any_hi_s) begin
            state_r   <= ST_TRIP;
            inhibit_r <= 1'b1;
            trip_r    <= 1'b1;
            cause_r   <= cause_s;
            hold_r    <= HOLD_LOAD;
          end else begin
            inhibit_r <= 1'b0;
          end
        end
        ST_TRIP: begin
          inhibit_r <= 1'b1;
          if (!init_done) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!init_done) begin
            state_r   <= ST_IDLE;
            inhibit_r <= 1'b1;
          end else if (hold_r == 8'd0) begin
            // Re-arm only after the host has dropped ptt: no automatic re-key.
            if (!ptt) begin
              state_r   <= ST_ARMED;
              inhibit_r <= 1'b0;
            end else begin
              inhibit_r <= 1'b1;
            end
          end else begin
            inhibit_r <= 1'b1;
            if (tick_s) begin
              hold_r <= hold_r - 8'd1;
            end else begin
              hold_r <= hold_r;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          inhibit_r <= 1'b1;
        end
      endcase
    end
  end

  // ptt release must reach the PA without a clock of delay.
  assign ptt_out    = ptt & ~inhibit_r;
  assign fwd_avg    = fwd_avg_s;
  assign ref_avg    = ref_avg_s;
  assign trip       = trip_r;
  assign trip_cause = cause_r;

endmodule

// File: tb/tb_pa_protect.sv
// Self-checking bench for pa_protect: table of single-tick trip scenarios
// plus hand-written sequences for latency, hold, reset and averaging.
module tb_pa_protect;

  logic        clock = 1'b0;
  logic        reset;
  logic        init_done;
  logic        ptt;
  logic [11:0] ain1, ain2;
  logic        ptt_out, trip;
  logic [11:0] fwd_avg, ref_avg;
  logic [1:0]  trip_cause;

  logic [11:0] ain1_b, ain2_b;
  logic        ptt_b;
  logic        ptt_out_b, trip_b;
  logic [11:0] fwd_avg_b, ref_avg_b;
  logic [1:0]  trip_cause_b;

  int checks = 0;
  int errors = 0;

`ifdef PA_PROTECT_SWR_EN
  localparam logic [1:0] SWRC = 2'd3;
`else
  localparam logic [1:0] SWRC = 2'd0;
`endif

  typedef struct {
    logic [11:0] a1;
    logic [11:0] a2;
    logic [1:0]  cause;
  } vec_t;

  vec_t vecs[12];
  vec_t sbq[$];
  int   ema_q[$];

  always #5 clock = ~clock;

  pa_protect #(.SAMPLE_DIV(4), .AVG_SHIFT(0), .HOLD_TICKS(2)) dut_a (
    .clock(clock), .reset(reset), .init_done(init_done),
    .ain1(ain1), .ain2(ain2), .ptt(ptt), .ptt_out(ptt_out),
    .fwd_avg(fwd_avg), .ref_avg(ref_avg), .trip(trip), .trip_cause(trip_cause)
  );

  pa_protect #(.SAMPLE_DIV(4), .AVG_SHIFT(3)) dut_b (
    .clock(clock), .reset(reset), .init_done(init_done),
    .ain1(ain1_b), .ain2(ain2_b), .ptt(ptt_b), .ptt_out(ptt_out_b),
    .fwd_avg(fwd_avg_b), .ref_avg(ref_avg_b), .trip(trip_b), .trip_cause(trip_cause_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int   pulses;
    int   prev;
    int   budget;
    bit   found;

    vecs[0]  = '{12'd3600, 12'd0,    2'd1};
    vecs[1]  = '{12'd1000, 12'd300,  SWRC};
    vecs[2]  = '{12'd3600, 12'd1300, 2'd1};
    vecs[3]  = '{12'd1000, 12'd1300, 2'd2};
    vecs[4]  = '{12'd2000, 12'd400,  2'd0};
    vecs[5]  = '{12'd300,  12'd200,  2'd0};
    vecs[6]  = '{12'd3500, 12'd0,    2'd0};
    vecs[7]  = '{12'd3501, 12'd0,    2'd1};
    vecs[8]  = '{12'd2000, 12'd1200, SWRC};
    vecs[9]  = '{12'd2000, 12'd1201, 2'd2};
    vecs[10] = '{12'd400,  12'd101,  SWRC};
    vecs[11] = '{12'd400,  12'd100,  2'd0};

    reset = 1'b1; init_done = 1'b0; ptt = 1'b1;
    ain1 = 12'd0; ain2 = 12'd0; ain1_b = 12'd0; ain2_b = 12'd0; ptt_b = 1'b0;
    cyc(2); #1;
    chk("rst_ptt_out", ptt_out, 0);
    chk("rst_fwd_avg", fwd_avg, 0);
    chk("rst_ref_avg", ref_avg, 0);
    chk("rst_trip", trip, 0);
    chk("rst_cause", trip_cause, 0);

    // First-tick latency and trip pulse
    ain1 = 12'd3600;
    @(negedge clock); reset = 1'b0; init_done = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock); #1;
      if (fwd_avg == 12'd3600) found = 1'b1;
    end
    chk("first_tick_avg", found, 1);
    chk("pre_trip_pulse", trip, 0);
    chk("pre_trip_ptt_out", ptt_out, 1);
    @(negedge clock); #1;
    chk("trip_pulse", trip, 1);
    chk("trip_cause_fwd", trip_cause, 1);
    chk("trip_ptt_out", ptt_out, 0);
    @(negedge clock); #1;
    chk("trip_one_cycle", trip, 0);

    // Hold expiry with ptt still high: no re-key
    cyc(20); #1;
    chk("hold_ptt_high", ptt_out, 0);
    ain1 = 12'd0;
    cyc(6); #1;
    chk("avg_follow_zero", fwd_avg, 0);
    chk("still_inhibited", ptt_out, 0);
    ptt = 1'b0;
    @(negedge clock); ptt = 1'b1; #1;
    chk("rearm_ptt_out", ptt_out, 1);
    chk("cause_kept_armed", trip_cause, 1);

    // init_done drop -> IDLE, cause kept
    init_done = 1'b0;
    @(negedge clock); #1;
    chk("initdrop_ptt_out", ptt_out, 0);
    chk("initdrop_cause", trip_cause, 1);
    init_done = 1'b1;
    @(negedge clock); #1;
    chk("initback_ptt_out", ptt_out, 1);

    // Table of single-tick scenarios
    for (int v = 0; v < 12; v++) begin
      reset = 1'b1; init_done = 1'b0; ptt = 1'b1;
      ain1 = vecs[v].a1; ain2 = vecs[v].a2;
      sbq.push_back(vecs[v]);
      cyc(2);
      reset = 1'b0; init_done = 1'b1;
      pulses = 0;
      repeat (12) begin
        @(negedge clock); #1;
        if (trip) pulses++;
      end
      e = sbq.pop_front();
      chk($sformatf("v%0d_fwd_avg", v), fwd_avg, e.a1);
      chk($sformatf("v%0d_ref_avg", v), ref_avg, e.a2);
      chk($sformatf("v%0d_cause", v), trip_cause, e.cause);
      chk($sformatf("v%0d_pulses", v), pulses, (e.cause != 2'd0) ? 1 : 0);
      chk($sformatf("v%0d_ptt_out", v), ptt_out, (e.cause != 2'd0) ? 0 : 1);
    end

    // Reset in the middle of HOLD
    reset = 1'b1; init_done = 1'b0; ptt = 1'b1;
    ain1 = 12'd3600; ain2 = 12'd1300;
    cyc(2);
    reset = 1'b0; init_done = 1'b1;
    cyc(8); #1;
    chk("hold_cause_prio", trip_cause, 1);
    chk("hold_inhibit", ptt_out, 0);
    reset = 1'b1; #1;
    chk("midhold_rst_fwd", fwd_avg, 0);
    chk("midhold_rst_ref", ref_avg, 0);
    chk("midhold_rst_trip", trip, 0);
    chk("midhold_rst_cause", trip_cause, 0);
    chk("midhold_rst_ptt_out", ptt_out, 0);
    ain1 = 12'd0; ain2 = 12'd0; init_done = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(2); #1;
    chk("idle_ptt_out", ptt_out, 0);
    init_done = 1'b1;
    @(negedge clock); #1;
    chk("armed_after_rst", ptt_out, 1);

    // Averaging step response at AVG_SHIFT=3
    reset = 1'b1; init_done = 1'b0;
    ain1_b = 12'd4095;
    ema_q.push_back(511); ema_q.push_back(959); ema_q.push_back(1351);
    cyc(2);
    reset = 1'b0; init_done = 1'b1;
    prev = 0; budget = 0;
    while (ema_q.size() > 0 && budget < 40) begin
      @(negedge clock); #1;
      budget++;
      if (int'(fwd_avg_b) != prev) begin
        chk($sformatf("ema_step_%0d", 3 - ema_q.size()), fwd_avg_b, ema_q.pop_front());
        prev = int'(fwd_avg_b);
      end
    end
    chk("ema_done", ema_q.size(), 0);
    chk("ema_ref_zero", ref_avg_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
